// File: rtl/qbert_move_ctrl.sv
// -----------------------------------------------------------------------------
// qbert_move_ctrl
// Moves Q*bert across a triangular pyramid of cubes. Each accepted move steps
// the sprite centre toward the target cube once per video frame. After
// HOP_FRAMES frames the sprite snaps to the exact target centre and landed_o
// pulses.
//
// Optional feature macro: QBERT_FALL_EN
//   defined   : a move off the pyramid enters FALL. The sprite drifts down
//               until it reaches FALL_Y_LIMIT, then fell_o pulses and Q*bert
//               respawns on cube (0,0).
//   undefined : a move off the pyramid is accepted and discarded.
//
// Reset is asynchronous and active-low. The port is named "reset".
// -----------------------------------------------------------------------------
module qbert_move_ctrl #(
    parameter int          ROWS         = 7,
    parameter logic [10:0] X_ORIGIN     = 11'd400,
    parameter logic [9:0]  Y_ORIGIN     = 10'd200,
    parameter logic [10:0] XSTEP        = 11'd50,
    parameter logic [9:0]  YSTEP        = 10'd90,
    parameter int          HOP_FRAMES   = 10,
    parameter logic [9:0]  FALL_Y_LIMIT = 10'd600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick_i,
    input  logic        cmd_valid_i,
    input  logic [1:0]  cmd_dir_i,
    output logic        cmd_ready_o,
    output logic [10:0] qbert_x_o,
    output logic [9:0]  qbert_y_o,
    output logic [5:0]  cube_idx_o,
    output logic        landed_o,
    output logic        fell_o
);

    // Row and column registers are sized for pyramids of up to 15 rows.
    localparam int RW = 4;
    localparam int CW = $clog2(HOP_FRAMES + 1);

    localparam logic [CW-1:0] LAST_TICK = CW'(HOP_FRAMES - 1);

    // Per-frame movement, kept as two's complement values in the output widths.
    localparam int          DX_I   = int'(XSTEP) / HOP_FRAMES;
    localparam int          DY_I   = int'(YSTEP) / HOP_FRAMES;
    localparam logic [10:0] DX     = 11'(DX_I);
    localparam logic [10:0] NEG_DX = 11'(-DX_I);
    localparam logic [9:0]  DY     = 10'(DY_I);
    localparam logic [9:0]  NEG_DY = 10'(-DY_I);

    // Reject parameter sets that would leave a hop short of its target or
    // end a fall above the pyramid apex.
    if (((int'(XSTEP) % HOP_FRAMES) != 0) || ((int'(YSTEP) % HOP_FRAMES) != 0)) begin : g_bad_step
        $error("XSTEP and YSTEP must be multiples of HOP_FRAMES");
    end
    if (FALL_Y_LIMIT <= Y_ORIGIN) begin : g_bad_limit
        $error("FALL_Y_LIMIT must lie below the pyramid origin");
    end

    typedef enum logic [1:0] {
        DIR_UR = 2'd0,
        DIR_UL = 2'd1,
        DIR_DR = 2'd2,
        DIR_DL = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOP  = 2'd1
`ifdef QBERT_FALL_EN
        ,
        S_FALL = 2'd2
`endif
    } state_e;

    state_e        state_q;
    logic [RW-1:0] row_q, col_q;
    logic [RW-1:0] tgt_row_q, tgt_col_q;
    logic [10:0]   tgt_x_q;
    logic [9:0]    tgt_y_q;
    logic [5:0]    tgt_idx_q;
    logic [10:0]   dx_q, x_q;
    logic [9:0]    dy_q, y_q;
    logic [CW-1:0] cnt_q;
    logic [5:0]    idx_q;
    logic          ready_q, landed_q, fell_q;

    // Signed target decode. Working in int lets r-1 and c-1 go negative so
    // that moves off the top or the left edge are flagged as illegal.
    int          nr, nc;
    logic        legal;
    logic [10:0] step_x;
    logic [9:0]  step_y;
    logic [10:0] tgt_x;
    logic [9:0]  tgt_y;
    logic [5:0]  tgt_idx;

    // Decode the target cube, its centre and its index from the requested direction.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned; an unassigned path in always_comb infers a latch.
        nr     = int'(row_q);
        nc     = int'(col_q);
        step_x = DX;
        step_y = DY;
        case (dir_e'(cmd_dir_i))
            DIR_UR: begin nr = nr - 1;                  step_x = DX;     step_y = NEG_DY; end
            DIR_UL: begin nr = nr - 1; nc = nc - 1;     step_x = NEG_DX; step_y = NEG_DY; end
            DIR_DR: begin nr = nr + 1; nc = nc + 1;     step_x = DX;     step_y = DY;     end
            default: begin nr = nr + 1;                 step_x = NEG_DX; step_y = DY;     end
        endcase
        legal   = (nc >= 0) && (nc <= nr) && (nr < ROWS);
        tgt_x   = 11'(int'(X_ORIGIN) + (2 * nc - nr) * int'(XSTEP));
        tgt_y   = 10'(int'(Y_ORIGIN) + nr * int'(YSTEP));
        tgt_idx = 6'((nr * (nr + 1)) / 2 + nc);
    end

    // Move FSM: accept commands in IDLE, step per frame in HOP or FALL, and
    // produce all outputs from registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            tgt_row_q <= '0;
            tgt_col_q <= '0;
            tgt_x_q   <= X_ORIGIN;
            tgt_y_q   <= Y_ORIGIN;
            tgt_idx_q <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            x_q       <= X_ORIGIN;
            y_q       <= Y_ORIGIN;
            cnt_q     <= '0;
            idx_q     <= '0;
            ready_q   <= 1'b1;
            landed_q  <= 1'b0;
            fell_q    <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments. Every
            // register then takes its value from the same pre-edge snapshot,
            // whatever order the statements are in.
            landed_q <= 1'b0;
            fell_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Command acceptance takes priority; a frame tick in the
                    // same cycle does not move the sprite.
                    if (cmd_valid_i) begin
                        if (legal) begin
                            state_q   <= S_HOP;
                            ready_q   <= 1'b0;
                            tgt_row_q <= RW'(nr);
                            tgt_col_q <= RW'(nc);
                            tgt_x_q   <= tgt_x;
                            tgt_y_q   <= tgt_y;
                            tgt_idx_q <= tgt_idx;
                            dx_q      <= step_x;
                            dy_q      <= step_y;
                            cnt_q     <= '0;
                        end
`ifdef QBERT_FALL_EN
                        else begin
                            // Off the pyramid: keep the sideways drift and
                            // always fall downward.
                            state_q <= S_FALL;
                            ready_q <= 1'b0;
                            dx_q    <= step_x;
                            dy_q    <= DY;
                        end
`endif
                    end
                end
                S_HOP: begin
                    if (frame_tick_i) begin
                        if (cnt_q == LAST_TICK) begin
                            // Snap to the exact centre so that no rounding
                            // error builds up from one hop to the next.
                            x_q      <= tgt_x_q;
                            y_q      <= tgt_y_q;
                            row_q    <= tgt_row_q;
                            col_q    <= tgt_col_q;
                            idx_q    <= tgt_idx_q;
                            cnt_q    <= '0;
                            landed_q <= 1'b1;
                            ready_q  <= 1'b1;
                            state_q  <= S_IDLE;
                        end else begin
                            x_q   <= x_q + dx_q;
                            y_q   <= y_q + dy_q;
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
`ifdef QBERT_FALL_EN
                S_FALL: begin
                    if (frame_tick_i) begin
                        if (y_q >= FALL_Y_LIMIT) begin
                            x_q     <= X_ORIGIN;
                            y_q     <= Y_ORIGIN;
                            row_q   <= '0;
                            col_q   <= '0;
                            idx_q   <= '0;
                            cnt_q   <= '0;
                            fell_q  <= 1'b1;
                            ready_q <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            x_q <= x_q + dx_q;
                            y_q <= y_q + dy_q;
                        end
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready_o = ready_q;
    assign qbert_x_o   = x_q;
    assign qbert_y_o   = y_q;
    assign cube_idx_o  = idx_q;
    assign landed_o    = landed_q;
    assign fell_o      = fell_q;

endmodule

// File: tb/tb_qbert_move_ctrl.sv
// -----------------------------------------------------------------------------
// tb_qbert_move_ctrl
// Directed bench for qbert_move_ctrl. Stimulus pushes the expected landing or
// fall event into a scoreboard queue. A monitor pops an entry each time the
// DUT pulses landed/fell and compares it. Any pulse with nothing queued
// counts as an error. Define QBERT_FALL_EN for both files to cover the fall
// path.
// -----------------------------------------------------------------------------
module tb_qbert_move_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic        cmd_valid;
    logic [1:0]  cmd_dir;
    logic        cmd_ready;
    logic [10:0] qbert_x;
    logic [9:0]  qbert_y;
    logic [5:0]  cube_idx;
    logic        landed;
    logic        fell;

    localparam logic [1:0] UR = 2'd0, UL = 2'd1, DR = 2'd2, DL = 2'd3;

    typedef struct {
        bit    is_fall;
        int    x;
        int    y;
        int    idx;
        string name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    qbert_move_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick_i (frame_tick),
        .cmd_valid_i  (cmd_valid),
        .cmd_dir_i    (cmd_dir),
        .cmd_ready_o  (cmd_ready),
        .qbert_x_o    (qbert_x),
        .qbert_y_o    (qbert_y),
        .cube_idx_o   (cube_idx),
        .landed_o     (landed),
        .fell_o       (fell)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_pos(input string name, input int ex, input int ey, input int eidx);
        check({name, ".x"}, int'(qbert_x), ex);
        check({name, ".y"}, int'(qbert_y), ey);
        check({name, ".idx"}, int'(cube_idx), eidx);
    endtask

    // Monitor: every landed/fell pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && (landed === 1'b1 || fell === 1'b1)) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_pulse: landed=%0b fell=%0b at (%0d,%0d), expected none",
                         landed, fell, qbert_x, qbert_y);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, ".kind_fell"}, int'(fell), int'(e.is_fall));
                check({e.name, ".kind_landed"}, int'(landed), int'(!e.is_fall));
                check({e.name, ".ev_x"}, int'(qbert_x), e.x);
                check({e.name, ".ev_y"}, int'(qbert_y), e.y);
                check({e.name, ".ev_idx"}, int'(cube_idx), e.idx);
            end
        end
    end

    // Every drive helper starts and ends 1 time unit after a rising edge.
    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input bit is_fall, input int x, input int y, input int idx, input string name);
        exp_t e;
        e.is_fall = is_fall;
        e.x       = x;
        e.y       = y;
        e.idx     = idx;
        e.name    = name;
        sb.push_back(e);
    endtask

    task automatic send_cmd(input logic [1:0] dir, input string name);
        int waited = 0;
        while (cmd_ready !== 1'b1 && waited < 100) begin
            cycles(1);
            waited++;
        end
        check({name, ".ready_before_cmd"}, int'(cmd_ready === 1'b1), 1);
        cmd_dir   = dir;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        frame_tick = 1'b0;
        cmd_valid  = 1'b0;
        cmd_dir    = 2'd0;
        cycles(3);

        // Reset state.
        check_pos("reset", 400, 200, 0);
        check("reset.ready", int'(cmd_ready), 1);
        check("reset.landed", int'(landed), 0);
        check("reset.fell", int'(fell), 0);
        reset = 1'b1;
        cycles(2);

`ifdef QBERT_FALL_EN
        // UR from (0,0) is off the pyramid: drift +5/+9 per tick, then respawn.
        push(1'b1, 400, 200, 0, "fall_ur");
        send_cmd(UR, "fall_ur");
        check("fall_ur.ready_low", int'(cmd_ready), 0);
        tick();
        check_pos("fall_ur.tick1", 405, 209, 0);
        ticks(44);
        check_pos("fall_ur.tick45", 625, 605, 0);
        check("fall_ur.no_fell_yet", int'(fell), 0);
        tick();
        check("fall_ur.fell_pulse", int'(fell), 1);
        cycles(2);
        check("fall_ur.ready_after", int'(cmd_ready), 1);
`else
        // UL from (0,0) is off the pyramid: accepted and dropped.
        send_cmd(UL, "illegal_ul");
        check("illegal_ul.ready", int'(cmd_ready), 1);
        check_pos("illegal_ul.pos", 400, 200, 0);
        ticks(3);
        check_pos("illegal_ul.after_ticks", 400, 200, 0);
`endif

        // Down-right from (0,0) to (1,1).
        push(1'b0, 450, 290, 2, "dr_hop");
        send_cmd(DR, "dr_hop");
        check("dr_hop.ready_low", int'(cmd_ready), 0);
        tick();
        check_pos("dr_hop.tick1", 405, 209, 0);
        ticks(8);
        check_pos("dr_hop.tick9", 445, 281, 0);
        tick();
        check_pos("dr_hop.tick10", 450, 290, 2);
        check("dr_hop.landed_now", int'(landed), 1);
        cycles(2);

        // Up-left from (1,1) back to (0,0).
        push(1'b0, 400, 200, 0, "ul_hop");
        send_cmd(UL, "ul_hop");
        tick();
        check_pos("ul_hop.tick1", 445, 281, 2);
        ticks(9);
        check_pos("ul_hop.done", 400, 200, 0);
        cycles(2);

        // Tick arriving in the acceptance cycle must not move the sprite.
        push(1'b0, 450, 290, 2, "same_cycle");
        cmd_dir    = DR;
        cmd_valid  = 1'b1;
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        frame_tick = 1'b0;
        check_pos("same_cycle.unmoved", 400, 200, 0);
        ticks(9);
        check_pos("same_cycle.tick9", 445, 281, 0);
        check("same_cycle.not_landed", int'(landed), 0);
        tick();
        check_pos("same_cycle.done", 450, 290, 2);
        cycles(2);

        // Back to (0,0), then hold cmd_valid during a hop without any ticks.
        push(1'b0, 400, 200, 0, "back_home");
        send_cmd(UL, "back_home");
        ticks(10);
        cycles(2);
        push(1'b0, 450, 290, 2, "held_cmd");
        send_cmd(DR, "held_cmd");
        cmd_dir   = UR;
        cmd_valid = 1'b1;
        cycles(50);
        check("held_cmd.ready_low", int'(cmd_ready), 0);
        check_pos("held_cmd.frozen", 400, 200, 0);
        cmd_valid = 1'b0;
        ticks(10);
        cycles(20);
        check_pos("held_cmd.single_hop", 450, 290, 2);
        check("held_cmd.ready_back", int'(cmd_ready), 1);

`ifndef QBERT_FALL_EN
        // UR from (1,1) targets (0,1): column beyond the row, so illegal.
        send_cmd(UR, "illegal_col");
        ticks(3);
        check_pos("illegal_col.pos", 450, 290, 2);
        check("illegal_col.ready", int'(cmd_ready), 1);
`endif

        // Down-left from (1,1) toward (2,1), then reset after tick 5.
        send_cmd(DL, "rst_mid");
        ticks(5);
        check_pos("rst_mid.tick5", 425, 335, 2);
        reset = 1'b0;
        #1;
        check_pos("rst_mid.async", 400, 200, 0);
        check("rst_mid.ready", int'(cmd_ready), 1);
        cycles(3);
        reset = 1'b1;
        cycles(20);
        check_pos("rst_mid.after", 400, 200, 0);
        check("rst_mid.no_landed", int'(landed), 0);

        cycles(5);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard stop in case a helper ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
